falafel_mem_responder: RTL and testbench
========================================

FALAFEL_MEM_RESPONDER -- requirements
Module: falafel_mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024, meaning the number of DATA_W-bit storage words.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the cycles from request accept to rsp_val (legal range 1..15).
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning the byte address of word 0.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
REQ-005 The request ports SHALL be:
- mem_req_val_i  in  1  request valid
- mem_req_rdy_o  out  1  responder ready
- mem_req_is_write_i  in  1  1 write/CAS, 0 read
- mem_req_is_cas_i  in  1  1 CAS, 0 plain write
- mem_req_addr_i  in  DATA_W  byte address
- mem_req_data_i  in  DATA_W  write/swap data
- mem_req_cas_exp_i  in  DATA_W  CAS expected value
REQ-006 The response and status ports SHALL be:
- mem_rsp_val_o  out  1  response valid
- mem_rsp_rdy_i  in  1  initiator ready
- mem_rsp_data_o  out  DATA_W  response data
- mem_err_o  out  1  sticky out-of-range flag

Function
REQ-007 The block SHALL accept a request on a rising edge where mem_req_val_i && mem_req_rdy_o, with one request outstanding at most.
REQ-008 The FSM SHALL have three states: IDLE (rdy_o=1, rsp_val_o=0), WAIT (both 0, latency counter running), RESP (rsp_val_o=1, rdy_o=0).
REQ-009 On accept, the FSM SHALL go to RESP if LATENCY==1; otherwise it SHALL go to WAIT with counter=LATENCY-1.
REQ-010 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 1, so rsp_val_o first rises exactly LATENCY cycles after the accept edge.
REQ-011 In RESP, mem_rsp_val_o and mem_rsp_data_o SHALL be held stable until mem_rsp_val_o && mem_rsp_rdy_i, after which the FSM SHALL return to IDLE.
REQ-012 The earliest next accept SHALL be one cycle after the response handshake, and the block SHALL never accept and respond in the same cycle.
REQ-013 The operation SHALL be decoded at accept:
- is_write=0: READ; is_cas is ignored.
- is_write=1, is_cas=0: WRITE.
- is_write=1, is_cas=1: CAS.
REQ-014 The word index SHALL be (addr-BASE_ADDR)>>$clog2(DATA_W/8); address LSBs below word alignment SHALL be ignored.
REQ-015 The address SHALL be in range iff addr>=BASE_ADDR and index<MEM_WORDS.
REQ-016 Storage SHALL be updated on the accept edge, and the response data SHALL be captured on that same edge:
- READ: returns the stored word.
- WRITE: stores the data; returns mem_req_data_i.
- CAS: returns the old word; stores mem_req_data_i only if old==mem_req_cas_exp_i.
REQ-017 An out-of-range request SHALL return 0, SHALL leave storage unchanged, still SHALL complete the handshake, and SHALL set mem_err_o, which stays 1 until reset.
REQ-018 mem_req_val_i while not in IDLE SHALL be ignored; request inputs SHALL be sampled only at accept.
REQ-019 Every accepted request SHALL produce exactly one response, in order.

Reset
REQ-020 On rst_ni low the FSM SHALL enter IDLE asynchronously, with mem_req_rdy_o=1 after reset release, mem_rsp_val_o=0, mem_rsp_data_o=0, mem_err_o=0, and counter=0.
REQ-021 Reset mid-operation SHALL discard the outstanding response; storage contents SHALL NOT be reset and SHALL retain prior writes.

Structure
REQ-022 DATA_W and a new enum mem_op_e {MEM_READ, MEM_WRITE, MEM_CAS} SHALL live in falafel_pkg; the FSM state enum SHALL stay local.
REQ-023 Storage SHALL be a sub-module falafel_mem_array with combinational read, a synchronous write enable, and no reset; FSM, decode and CAS compare SHALL stay in the top.

Verification
REQ-024 With LATENCY=2 and rsp_rdy=1, WRITE addr 0x10 data 0xAB, then READ 0x10 -> responses 0xAB then 0xAB, each rsp_val rising 2 cycles after its accept.
REQ-025 With word 0x10=5, CAS exp 5 data 9 -> rsp 5; then READ -> 9; then CAS exp 5 data 7 -> rsp 9; then READ -> 9.
REQ-026 Hold mem_rsp_rdy_i=0 for 6 cycles in RESP -> val and data stable, rdy_o=0 throughout, and a second request presented meanwhile is not accepted until 1 cycle after the handshake.
REQ-027 READ at index MEM_WORDS (addr 0x2000 with DATA_W=64, MEM_WORDS=1024) -> rsp 0 and mem_err_o=1 sticky; a following valid READ succeeds and err stays 1.
REQ-028 Assert rst_ni low while in WAIT -> rsp_val never rises, rdy_o=1 after release; a READ of a location written before reset returns the old value.
REQ-029 With LATENCY=1, run 20 random back-to-back ops against a reference model -> data match and rsp_val 1 cycle after each accept.

Source files
------------

// File: rtl/falafel_pkg.sv
// rtl/falafel_pkg.sv - shared width, operation type and decode helper for the falafel memory responder
//
// Contents:
//   DATA_W      data and address width in bits
//   BYTE_SHIFT  shift from byte address to word index
//   mem_op_e    operation carried by an accepted request
//   decode_op   maps the is_write/is_cas request bits onto mem_op_e

package falafel_pkg;

    localparam int DATA_W     = 64;
    localparam int BYTE_SHIFT = $clog2(DATA_W / 8);

    typedef enum logic [1:0] {
        MEM_READ,
        MEM_WRITE,
        MEM_CAS
    } mem_op_e;

    // is_cas only has meaning for writes; a read with is_cas set is a plain read.
    function automatic mem_op_e decode_op(input logic is_write, input logic is_cas);
        mem_op_e op;
        if (!is_write) begin
            op = MEM_READ;
        end else if (is_cas) begin
            op = MEM_CAS;
        end else begin
            op = MEM_WRITE;
        end
        return op;
    endfunction

endpackage

// File: rtl/falafel_mem_array.sv
// rtl/falafel_mem_array.sv - word storage with combinational read and synchronous write
//
// Ports:
//   clk    clock
//   we     write enable, takes effect on the rising edge
//   addr   word index shared by read and write
//   wdata  word to store
//   rdata  word currently stored at addr (combinational)
//
// Contents are deliberately not reset so that data survives a responder reset.

module falafel_mem_array
    import falafel_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int IDX_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/falafel_mem_responder.sv
// rtl/falafel_mem_responder.sv - single-outstanding memory responder with read, write and compare-and-swap
//
// Parameters:
//   MEM_WORDS  number of DATA_W-bit words of storage
//   LATENCY    cycles from request accept to mem_rsp_val_o (1..15)
//   BASE_ADDR  byte address of word 0
//
// Ports:
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   mem_req_val_i / mem_req_rdy_o    request handshake
//   mem_req_is_write_i               1 write/CAS, 0 read
//   mem_req_is_cas_i                 1 CAS, 0 plain write
//   mem_req_addr_i                   byte address
//   mem_req_data_i                   write / swap data
//   mem_req_cas_exp_i                CAS expected value
//   mem_rsp_val_o / mem_rsp_rdy_i    response handshake
//   mem_rsp_data_o                   response data
//   mem_err_o                        sticky out-of-range flag

module falafel_mem_responder
    import falafel_pkg::*;
#(
    parameter int                MEM_WORDS = 1024,
    parameter int                LATENCY   = 2,
    parameter logic [DATA_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    input  logic [DATA_W-1:0] mem_req_cas_exp_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o,
    output logic              mem_err_o
);

    localparam int         IDX_W    = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state;
    state_e      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        accept;

    logic [DATA_W:0]   addr_diff;
    logic [DATA_W-1:0] word_idx;
    logic              in_range;
    mem_op_e           op;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              cas_hit;
    logic [DATA_W-1:0] rsp_capture;
    logic [DATA_W-1:0] rsp_data;
    logic              err;

    assign accept = (state == S_IDLE) && mem_req_val_i;

    // Address decode. The extra top bit of the difference is the borrow,
    // which flags an address below BASE_ADDR without a separate compare.
    assign addr_diff = {1'b0, mem_req_addr_i} - {1'b0, BASE_ADDR};
    assign word_idx  = addr_diff[DATA_W-1:0] >> BYTE_SHIFT;
    assign in_range  = !addr_diff[DATA_W] && (word_idx < DATA_W'(MEM_WORDS));
    assign op        = decode_op(mem_req_is_write_i, mem_req_is_cas_i);

    falafel_mem_array #(
        .WORDS (MEM_WORDS),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk_i),
        .we    (mem_we),
        .addr  (word_idx[IDX_W-1:0]),
        .wdata (mem_req_data_i),
        .rdata (mem_rdata)
    );

    // Storage is written on the accept edge itself; the read port still shows
    // the old word during that cycle, which is what READ and CAS return.
    assign cas_hit = (mem_rdata == mem_req_cas_exp_i);
    assign mem_we  = accept && in_range &&
                     ((op == MEM_WRITE) || ((op == MEM_CAS) && cas_hit));

    always_comb begin
        rsp_capture = '0;
        if (in_range) begin
            case (op)
                MEM_READ:  rsp_capture = mem_rdata;
                MEM_WRITE: rsp_capture = mem_req_data_i;
                MEM_CAS:   rsp_capture = mem_rdata;
                default:   rsp_capture = '0;
            endcase
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        mem_req_rdy_o = 1'b0;
        mem_rsp_val_o = 1'b0;
        case (state)
            S_IDLE: begin
                mem_req_rdy_o = 1'b1;
                if (mem_req_val_i) begin
                    if (LATENCY == 1) begin
                        state_next = S_RESP;
                        cnt_next   = '0;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = LAT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // Leaving at cnt==1 puts rsp_val up exactly LATENCY edges after accept.
                if (cnt == 4'd1) begin
                    state_next = S_RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            S_RESP: begin
                mem_rsp_val_o = 1'b1;
                if (mem_rsp_rdy_i) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_data <= '0;
            err      <= 1'b0;
        end else if (accept) begin
            rsp_data <= rsp_capture;
            if (!in_range) begin
                err <= 1'b1;
            end
        end
    end

    assign mem_rsp_data_o = rsp_data;
    assign mem_err_o      = err;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// tb/tb_falafel_mem_responder.sv - scoreboard bench for falafel_mem_responder at LATENCY 2 and LATENCY 1

module tb_falafel_mem_responder;
    import falafel_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n    [2];
    logic              req_val  [2];
    logic              req_rdy  [2];
    logic              req_wr   [2];
    logic              req_cas  [2];
    logic [DATA_W-1:0] req_addr [2];
    logic [DATA_W-1:0] req_data [2];
    logic [DATA_W-1:0] req_exp  [2];
    logic              rsp_val  [2];
    logic              rsp_rdy  [2];
    logic [DATA_W-1:0] rsp_data [2];
    logic              err      [2];

    falafel_mem_responder #(
        .MEM_WORDS (1024),
        .LATENCY   (2),
        .BASE_ADDR (64'h0)
    ) dut0 (
        .clk_i              (clk),
        .rst_ni             (rst_n[0]),
        .mem_req_val_i      (req_val[0]),
        .mem_req_rdy_o      (req_rdy[0]),
        .mem_req_is_write_i (req_wr[0]),
        .mem_req_is_cas_i   (req_cas[0]),
        .mem_req_addr_i     (req_addr[0]),
        .mem_req_data_i     (req_data[0]),
        .mem_req_cas_exp_i  (req_exp[0]),
        .mem_rsp_val_o      (rsp_val[0]),
        .mem_rsp_rdy_i      (rsp_rdy[0]),
        .mem_rsp_data_o     (rsp_data[0]),
        .mem_err_o          (err[0])
    );

    falafel_mem_responder #(
        .MEM_WORDS (16),
        .LATENCY   (1),
        .BASE_ADDR (64'h100)
    ) dut1 (
        .clk_i              (clk),
        .rst_ni             (rst_n[1]),
        .mem_req_val_i      (req_val[1]),
        .mem_req_rdy_o      (req_rdy[1]),
        .mem_req_is_write_i (req_wr[1]),
        .mem_req_is_cas_i   (req_cas[1]),
        .mem_req_addr_i     (req_addr[1]),
        .mem_req_data_i     (req_data[1]),
        .mem_req_cas_exp_i  (req_exp[1]),
        .mem_rsp_val_o      (rsp_val[1]),
        .mem_rsp_rdy_i      (rsp_rdy[1]),
        .mem_rsp_data_o     (rsp_data[1]),
        .mem_err_o          (err[1])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] exp_q [$];
    int                acc_q [$];
    int                lat   [2] = '{2, 1};

    logic              pv    [2] = '{1'b0, 1'b0};
    logic              prdy  [2] = '{1'b0, 1'b0};
    logic [DATA_W-1:0] pdata [2];

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, want, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, records accept edges, checks
    // response latency, hold stability and data against the scoreboard.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst_n[u]) begin
                if (req_val[u] && req_rdy[u]) acc_q.push_back(cyc + 1);
                if (rsp_val[u] && !pv[u]) begin
                    if (acc_q.size() == 0) begin
                        check("latency_no_accept", 64'd1, 64'd0);
                    end else begin
                        int a;
                        a = acc_q.pop_front();
                        check("latency", 64'(cyc + 1 - a), 64'(lat[u]));
                    end
                end
                if (rsp_val[u]) check("req_rdy_in_resp", 64'(req_rdy[u]), 64'd0);
                if (rsp_val[u] && pv[u] && !prdy[u]) check("rsp_data_stable", rsp_data[u], pdata[u]);
                if (rsp_val[u] && rsp_rdy[u]) begin
                    if (exp_q.size() == 0) check("unexpected_rsp", 64'd1, 64'd0);
                    else check("rsp_data", rsp_data[u], exp_q.pop_front());
                end
            end
            pv[u]    = rsp_val[u];
            prdy[u]  = rsp_rdy[u];
            pdata[u] = rsp_data[u];
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accept edge.
    task automatic issue(input int u, input logic w, input logic c,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] x,
                         output int acc);
        int n;
        req_wr[u]   = w;
        req_cas[u]  = c;
        req_addr[u] = a;
        req_data[u] = d;
        req_exp[u]  = e;
        req_val[u]  = 1'b1;
        n = 0;
        while (!req_rdy[u] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_rdy[u]) begin
            check("accept_timeout", 64'd0, 64'd1);
            req_val[u] = 1'b0;
            acc = -1;
            return;
        end
        exp_q.push_back(x);
        acc = cyc + 1;
        @(posedge clk); #1;
        req_val[u] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a, acc_b, hs_a, dummy, stall_n, op, idx;
        logic [DATA_W-1:0] model [16];
        logic [DATA_W-1:0] a, d, e, x;

        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0; req_val[u] = 1'b0; req_wr[u] = 1'b0; req_cas[u] = 1'b0;
            req_addr[u] = '0; req_data[u] = '0; req_exp[u] = '0; rsp_rdy[u] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(posedge clk); #1;

        for (int u = 0; u < 2; u++) begin
            check("reset_rdy", 64'(req_rdy[u]), 64'd1);
            check("reset_val", 64'(rsp_val[u]), 64'd0);
            check("reset_data", rsp_data[u], 64'd0);
            check("reset_err", 64'(err[u]), 64'd0);
        end

        // Write then read back, LATENCY 2
        issue(0, 1'b1, 1'b0, 64'h10, 64'hAB, 64'h0, 64'hAB, dummy);
        issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'hAB, dummy);
        wait_idle();

        // CAS sequence; last read uses a misaligned address with is_cas set
        issue(0, 1'b1, 1'b0, 64'h10, 64'h5, 64'h0, 64'h5, dummy);
        issue(0, 1'b1, 1'b1, 64'h10, 64'h9, 64'h5, 64'h5, dummy);
        issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h9, dummy);
        issue(0, 1'b1, 1'b1, 64'h10, 64'h7, 64'h5, 64'h9, dummy);
        issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h9, dummy);
        issue(0, 1'b0, 1'b1, 64'h13, 64'h0, 64'h0, 64'h9, dummy);
        wait_idle();

        // Response stall with a second request waiting
        rsp_rdy[0] = 1'b0;
        hs_a = -10;
        acc_b = -1;
        fork
            begin
                issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h9, dummy);
                issue(0, 1'b1, 1'b0, 64'h18, 64'h55, 64'h0, 64'h55, acc_b);
            end
            begin
                stall_n = 0;
                while (!rsp_val[0] && stall_n < 50) begin
                    @(posedge clk); #1;
                    stall_n++;
                end
                check("stall_val_seen", 64'(rsp_val[0]), 64'd1);
                repeat (6) begin
                    @(posedge clk); #1;
                    check("stall_val_held", 64'(rsp_val[0]), 64'd1);
                    check("stall_rdy_low", 64'(req_rdy[0]), 64'd0);
                end
                rsp_rdy[0] = 1'b1;
                hs_a = cyc + 1;
            end
        join
        check("accept_after_hs", 64'(acc_b), 64'(hs_a + 1));
        wait_idle();

        // Last valid word, then out of range at index MEM_WORDS
        issue(0, 1'b1, 1'b0, 64'h1FF8, 64'h1234, 64'h0, 64'h1234, dummy);
        issue(0, 1'b0, 1'b0, 64'h1FF8, 64'h0, 64'h0, 64'h1234, dummy);
        wait_idle();
        check("err_before_oor", 64'(err[0]), 64'd0);
        issue(0, 1'b0, 1'b0, 64'h2000, 64'h0, 64'h0, 64'h0, dummy);
        wait_idle();
        check("err_after_oor", 64'(err[0]), 64'd1);
        issue(0, 1'b0, 1'b0, 64'h18, 64'h0, 64'h0, 64'h55, dummy);
        wait_idle();
        check("err_sticky", 64'(err[0]), 64'd1);

        // Reset while in WAIT: response discarded, storage retained
        issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h9, acc_a);
        rst_n[0] = 1'b0;
        exp_q.delete();
        acc_q.delete();
        check("rst_val_low", 64'(rsp_val[0]), 64'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst_hold_val", 64'(rsp_val[0]), 64'd0);
        end
        rst_n[0] = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_val", 64'(rsp_val[0]), 64'd0);
            check("post_rst_rdy", 64'(req_rdy[0]), 64'd1);
        end
        check("post_rst_err", 64'(err[0]), 64'd0);
        check("post_rst_data", rsp_data[0], 64'd0);
        issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'h0, 64'h9, dummy);
        wait_idle();

        // LATENCY 1, base 0x100: fill, then 20 random back-to-back ops
        for (int i = 0; i < 16; i++) begin
            model[i] = {$urandom, $urandom};
            issue(1, 1'b1, 1'b0, 64'h100 + 64'(i * 8), model[i], 64'h0, model[i], dummy);
        end
        for (int k = 0; k < 20; k++) begin
            op  = int'($urandom_range(0, 2));
            idx = int'($urandom_range(0, 15));
            a   = 64'h100 + 64'(idx * 8) + 64'($urandom_range(0, 7));
            d   = {$urandom, $urandom};
            e   = ($urandom_range(0, 1) == 1) ? model[idx] : {$urandom, $urandom};
            if (op == 0) begin
                x = model[idx];
                issue(1, 1'b0, 1'($urandom_range(0, 1)), a, d, e, x, dummy);
            end else if (op == 1) begin
                x = d;
                model[idx] = d;
                issue(1, 1'b1, 1'b0, a, d, e, x, dummy);
            end else begin
                x = model[idx];
                if (model[idx] == e) model[idx] = d;
                issue(1, 1'b1, 1'b1, a, d, e, x, dummy);
            end
        end
        wait_idle();
        check("l1_err_clean", 64'(err[1]), 64'd0);

        // Below base and one past the end
        issue(1, 1'b0, 1'b0, 64'hF8, 64'h0, 64'h0, 64'h0, dummy);
        wait_idle();
        check("l1_err_below_base", 64'(err[1]), 64'd1);
        issue(1, 1'b1, 1'b0, 64'h180, 64'hDEAD, 64'h0, 64'h0, dummy);
        issue(1, 1'b0, 1'b0, 64'h178, 64'h0, 64'h0, model[15], dummy);
        wait_idle();
        check("l1_err_sticky", 64'(err[1]), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
